// File: rtl/ifu_fetch.sv
// Instruction-fetch front end: owns the PC, keeps one icache fetch in flight, and holds one instruction for IDU.
// Optional macro IFU_FAULT_HALT_EN: after a faulting response, stop fetching until a redirect arrives.

module ifu_fetch #(
    parameter int                  DATA_LEN = 32,
    parameter logic [DATA_LEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                clk,
    input  logic                rst_n,

    output logic                ifu_arvalid,
    input  logic                ifu_arready,
    output logic [DATA_LEN-3:0] ifu_raddr,
    input  logic                ifu_rvalid,
    output logic                ifu_rready,
    input  logic [31:0]         ifu_rdata,
    input  logic [2:0]          ifu_rresp,

    input  logic                redirect_valid,
    input  logic [DATA_LEN-1:0] redirect_pc,

    output logic                inst_valid,
    input  logic                inst_ready,
    output logic [31:0]         inst,
    output logic [DATA_LEN-1:0] inst_pc,
    output logic                inst_fault
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
`ifdef IFU_FAULT_HALT_EN
    localparam logic [1:0] ST_HALT = 2'd2;
`endif

    localparam logic [DATA_LEN-1:0] WORD_MASK = ~DATA_LEN'(3);
    localparam logic [DATA_LEN-1:0] PC_STEP   = DATA_LEN'(4);

    logic [1:0]          state, state_n;
    logic [DATA_LEN-1:0] pc, pc_n;
    logic [DATA_LEN-1:0] req_pc, req_pc_n;
    logic                stale, stale_n;
    logic                ar_hs, r_hs, out_hs;
    logic                load, resp_err;

    assign ar_hs    = ifu_arvalid & ifu_arready;
    assign r_hs     = ifu_rvalid & ifu_rready;
    assign out_hs   = inst_valid & inst_ready;
    assign resp_err = (ifu_rresp != 3'd0);

    assign ifu_raddr  = pc[DATA_LEN-1:2];
    // A stale response is always drained, even when the output register is full.
    assign ifu_rready = (state == ST_WAIT) & (~inst_valid | inst_ready | stale);

    // A fresh response is captured only if no redirect lands in the same cycle.
    assign load = r_hs & ~stale & ~redirect_valid;

    always_comb begin
        // NOTE: every next-state variable gets a default here, so no path through the case can infer a latch.
        state_n  = state;
        pc_n     = pc;
        req_pc_n = req_pc;
        stale_n  = stale;

        case (state)
            ST_REQ: begin
                if (ar_hs) begin
                    req_pc_n = pc;
                    pc_n     = pc + PC_STEP;
                    state_n  = ST_WAIT;
                    stale_n  = redirect_valid;
                end
            end
            ST_WAIT: begin
                if (r_hs) begin
                    stale_n = 1'b0;
                    state_n = ST_REQ;
`ifdef IFU_FAULT_HALT_EN
                    if (load && resp_err) begin
                        state_n = ST_HALT;
                    end
`endif
                end else if (redirect_valid) begin
                    stale_n = 1'b1;
                end
            end
`ifdef IFU_FAULT_HALT_EN
            ST_HALT: begin
                if (redirect_valid) begin
                    state_n = ST_REQ;
                end
            end
`endif
            default: state_n = ST_REQ;
        endcase

        // Redirect target overrides any sequential increment, including one from a same-cycle ar_hs.
        if (redirect_valid) begin
            pc_n = redirect_pc & WORD_MASK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            req_pc      <= '0;
            stale       <= 1'b0;
            ifu_arvalid <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state       <= state_n;
            pc          <= pc_n;
            req_pc      <= req_pc_n;
            stale       <= stale_n;
            // Registered so the request stays low throughout reset and rises one cycle after release.
            ifu_arvalid <= (state_n == ST_REQ);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_fault <= 1'b0;
        end else begin
            if (redirect_valid) begin
                inst_valid <= 1'b0;
            end else if (load) begin
                inst_valid <= 1'b1;
            end else if (out_hs) begin
                inst_valid <= 1'b0;
            end

            if (load) begin
                inst       <= ifu_rdata;
                inst_pc    <= req_pc;
                inst_fault <= resp_err;
            end
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small icache responder; honours IFU_FAULT_HALT_EN when defined.

module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_arvalid;
    logic        ifu_arready = 1'b1;
    logic [29:0] ifu_raddr;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] ifu_rdata;
    logic [2:0]  ifu_rresp;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    int          tests = 0;
    int          fails = 0;
    int          lat = 0;
    logic [31:0] fault_addr = '0;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_arvalid    (ifu_arvalid),
        .ifu_arready    (ifu_arready),
        .ifu_raddr      (ifu_raddr),
        .ifu_rvalid     (ifu_rvalid),
        .ifu_rready     (ifu_rready),
        .ifu_rdata      (ifu_rdata),
        .ifu_rresp      (ifu_rresp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_fault     (inst_fault)
    );

    always #5 clk = ~clk;

    // Icache responder: data word is the bitwise inverse of its byte address; lat extra cycles beyond a hit.
    initial begin : icache_model
        bit          ar_seen;
        bit          r_seen;
        bit          pending;
        logic [29:0] a;
        logic [29:0] paddr;
        int          cnt;
        pending    = 1'b0;
        paddr      = '0;
        cnt        = 0;
        ifu_rvalid = 1'b0;
        ifu_rdata  = '0;
        ifu_rresp  = '0;
        forever begin
            @(negedge clk);
            ar_seen = ifu_arvalid & ifu_arready;
            r_seen  = ifu_rvalid & ifu_rready;
            a       = ifu_raddr;
            @(posedge clk);
            #1;
            if (r_seen) begin
                ifu_rvalid = 1'b0;
                pending    = 1'b0;
            end
            if (ar_seen) begin
                pending = 1'b1;
                paddr   = a;
                cnt     = lat;
            end
            if (!rst_n) begin
                pending    = 1'b0;
                ifu_rvalid = 1'b0;
            end else if (pending && !ifu_rvalid) begin
                if (cnt == 0) begin
                    ifu_rvalid = 1'b1;
                    ifu_rdata  = ~{paddr, 2'b00};
                    ifu_rresp  = ({paddr, 2'b00} == fault_addr) ? 3'h2 : 3'h0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        ifu_arready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Returns the number of negedges waited until inst_valid is seen.
    task automatic wait_inst(input string name, output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (inst_valid) begin
                n = i;
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL %s: inst_valid timeout, got 0 want 1", name);
    endtask

    task automatic wait_ar(input string name, output bit saw_inst);
        saw_inst = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (inst_valid) saw_inst = 1'b1;
            if (ifu_arvalid && ifu_arready) return;
        end
        tests++;
        fails++;
        $display("FAIL %s: ar handshake timeout, got 0 want 1", name);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        ifu_arready    = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({ifu_arvalid, ifu_rready, inst_valid, inst_fault} !== 4'b0000 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs: got ar=%b r=%b v=%b f=%b inst=%h pc=%h want all zero",
                     ifu_arvalid, ifu_rready, inst_valid, inst_fault, inst, inst_pc);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (ifu_arvalid !== 1'b0) begin
            fails++;
            $display("FAIL arvalid_release_cycle: got %b want 0", ifu_arvalid);
        end
        @(negedge clk);
        tests++;
        if (ifu_arvalid !== 1'b1) begin
            fails++;
            $display("FAIL arvalid_rise: got %b want 1", ifu_arvalid);
        end
        tests++;
        if (ifu_raddr !== 30'h2000_0000) begin
            fails++;
            $display("FAIL first_raddr: got %h want 20000000", ifu_raddr);
        end
    endtask

    task automatic test_hits();
        logic [31:0] exp_pc [3] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008};
        logic [31:0] exp_d  [3] = '{32'h7FFF_FFFF, 32'h7FFF_FFFB, 32'h7FFF_FFF7};
        int          exp_n  [3] = '{4, 2, 2};
        int          n;
        apply_reset();
        lat        = 0;
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_inst("hits_wait", n);
            tests++;
            if (n !== exp_n[i]) begin
                fails++;
                $display("FAIL hits_latency[%0d]: got %0d cycles want %0d", i, n, exp_n[i]);
            end
            tests++;
            if (inst_pc !== exp_pc[i] || inst !== exp_d[i] || inst_fault !== 1'b0) begin
                fails++;
                $display("FAIL hits_data[%0d]: got pc=%h inst=%h f=%b want pc=%h inst=%h f=0",
                         i, inst_pc, inst, inst_fault, exp_pc[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        apply_reset();
        lat        = 0;
        inst_ready = 1'b0;
        wait_inst("stall_first", n);
        tests++;
        if (inst_pc !== 32'h8000_0000 || inst !== 32'h7FFF_FFFF) begin
            fails++;
            $display("FAIL stall_first: got pc=%h inst=%h want pc=80000000 inst=7fffffff", inst_pc, inst);
        end
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            tests++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 || inst !== 32'h7FFF_FFFF ||
                ifu_arvalid !== 1'b0 || ifu_rready !== 1'b0) begin
                fails++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h ar=%b rr=%b want v=1 pc=80000000 inst=7fffffff ar=0 rr=0",
                         k, inst_valid, inst_pc, inst, ifu_arvalid, ifu_rready);
            end
        end
        @(posedge clk);
        #1;
        inst_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8000_0000 || ifu_rready !== 1'b1) begin
            fails++;
            $display("FAIL stall_release: got v=%b pc=%h rr=%b want v=1 pc=80000000 rr=1", inst_valid, inst_pc, ifu_rready);
        end
        wait_inst("stall_second", n);
        tests++;
        if (n !== 1 || inst_pc !== 32'h8000_0004 || inst !== 32'h7FFF_FFFB) begin
            fails++;
            $display("FAIL stall_second: got n=%0d pc=%h inst=%h want n=1 pc=80000004 inst=7ffffffb", n, inst_pc, inst);
        end
        wait_inst("stall_third", n);
        tests++;
        if (inst_pc !== 32'h8000_0008 || inst !== 32'h7FFF_FFF7) begin
            fails++;
            $display("FAIL stall_third: got pc=%h inst=%h want pc=80000008 inst=7ffffff7", inst_pc, inst);
        end
    endtask

    task automatic test_redirect_wait();
        bit saw;
        int n;
        apply_reset();
        lat        = 6;
        inst_ready = 1'b1;
        wait_ar("rw_first_ar", saw);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_ar("rw_second_ar", saw);
        tests++;
        if (ifu_raddr !== 30'h2000_0040) begin
            fails++;
            $display("FAIL rw_raddr: got %h want 20000040", ifu_raddr);
        end
        tests++;
        if (saw !== 1'b0) begin
            fails++;
            $display("FAIL rw_stale_discard: got inst_valid=1 during drain want 0");
        end
        wait_inst("rw_inst", n);
        tests++;
        if (inst_pc !== 32'h8000_0100 || inst !== 32'h7FFF_FEFF) begin
            fails++;
            $display("FAIL rw_inst: got pc=%h inst=%h want pc=80000100 inst=7ffffeff", inst_pc, inst);
        end
        lat = 0;
    endtask

    task automatic test_redirect_ar();
        int n;
        apply_reset();
        lat        = 0;
        inst_ready = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        @(negedge clk);
        tests++;
        if (ifu_arvalid !== 1'b1 || ifu_raddr !== 30'h2000_0000) begin
            fails++;
            $display("FAIL rar_coincident: got ar=%b addr=%h want ar=1 addr=20000000", ifu_arvalid, ifu_raddr);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_inst("rar_inst", n);
        tests++;
        if (inst_pc !== 32'h8000_0200 || inst !== 32'h7FFF_FDFF) begin
            fails++;
            $display("FAIL rar_inst: got pc=%h inst=%h want pc=80000200 inst=7ffffdff", inst_pc, inst);
        end
    endtask

    task automatic test_redirect_req();
        int n;
        apply_reset();
        lat         = 0;
        ifu_arready = 1'b0;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (ifu_arvalid !== 1'b1 || ifu_raddr !== 30'h2000_00C0) begin
            fails++;
            $display("FAIL rreq_addr: got ar=%b addr=%h want ar=1 addr=200000c0", ifu_arvalid, ifu_raddr);
        end
        @(posedge clk);
        #1;
        ifu_arready = 1'b1;
        inst_ready  = 1'b1;
        wait_inst("rreq_inst", n);
        tests++;
        if (inst_pc !== 32'h8000_0300 || inst !== 32'h7FFF_FCFF) begin
            fails++;
            $display("FAIL rreq_inst: got pc=%h inst=%h want pc=80000300 inst=7ffffcff", inst_pc, inst);
        end
    endtask

    task automatic test_fault();
        logic [31:0] exp_pc [5] = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0008, 32'h8000_000C, 32'h8000_0010};
        logic [31:0] exp_d  [5] = '{32'h7FFF_FFFF, 32'h7FFF_FFFB, 32'h7FFF_FFF7, 32'h7FFF_FFF3, 32'h7FFF_FFEF};
        logic        exp_f  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int          n;
        apply_reset();
        lat        = 0;
        fault_addr = 32'h8000_0010;
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_inst("fault_seq", n);
            tests++;
            if (inst_pc !== exp_pc[i] || inst !== exp_d[i] || inst_fault !== exp_f[i]) begin
                fails++;
                $display("FAIL fault_seq[%0d]: got pc=%h inst=%h f=%b want pc=%h inst=%h f=%b",
                         i, inst_pc, inst, inst_fault, exp_pc[i], exp_d[i], exp_f[i]);
            end
        end
`ifdef IFU_FAULT_HALT_EN
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests++;
            if (ifu_arvalid !== 1'b0 || ifu_rready !== 1'b0) begin
                fails++;
                $display("FAIL halt_hold[%0d]: got ar=%b rr=%b want 0 0", k, ifu_arvalid, ifu_rready);
            end
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0020;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        wait_inst("halt_resume", n);
        tests++;
        if (inst_pc !== 32'h8000_0020 || inst !== 32'h7FFF_FFDF || inst_fault !== 1'b0) begin
            fails++;
            $display("FAIL halt_resume: got pc=%h inst=%h f=%b want pc=80000020 inst=7fffffdf f=0", inst_pc, inst, inst_fault);
        end
`else
        wait_inst("fault_continue", n);
        tests++;
        if (inst_pc !== 32'h8000_0014 || inst !== 32'h7FFF_FFEB || inst_fault !== 1'b0) begin
            fails++;
            $display("FAIL fault_continue: got pc=%h inst=%h f=%b want pc=80000014 inst=7fffffeb f=0", inst_pc, inst, inst_fault);
        end
`endif
        fault_addr = '0;
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        lat        = 0;
        inst_ready = 1'b0;
        wait_inst("rmid_first", n);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ifu_arvalid, ifu_rready, inst_valid, inst_fault} !== 4'b0000 || inst !== 32'h0 ||
            inst_pc !== 32'h0 || ifu_raddr !== 30'h2000_0000) begin
            fails++;
            $display("FAIL rmid_reset: got ar=%b rr=%b v=%b f=%b inst=%h pc=%h addr=%h want zeros addr=20000000",
                     ifu_arvalid, ifu_rready, inst_valid, inst_fault, inst, inst_pc, ifu_raddr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        wait_inst("rmid_refetch", n);
        tests++;
        if (n !== 4 || inst_pc !== 32'h8000_0000 || inst !== 32'h7FFF_FFFF) begin
            fails++;
            $display("FAIL rmid_refetch: got n=%0d pc=%h inst=%h want n=4 pc=80000000 inst=7fffffff", n, inst_pc, inst);
        end
    endtask

    initial begin
        test_reset();
        test_hits();
        test_stall();
        test_redirect_wait();
        test_redirect_ar();
        test_redirect_req();
        test_fault();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
